// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Registered, width-parametrised MIPS EX-stage ALU with
//             valid/ready handshakes on both sides. Decodes R/I-type words
//             and returns the result with {overflow, negative, zero} flags.
//  Options  : define ALU_MULT_EN to add an iterative MULT/MULTU unit with
//             HI/LO registers (mfhi/mflo become legal).
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam int MSB  = WIDTH - 1;
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_SRLV  = 6'h06;
    localparam logic [5:0] c_FN_SRAV  = 6'h07;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    // Instruction fields and derived operands
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [SH_W-1:0]  w_sa_imm;
    logic [SH_W-1:0]  w_sa_reg;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_zext;
    logic             w_unused_fields;

    // Shared arithmetic
    logic [WIDTH-1:0] w_sum_ab;
    logic [WIDTH-1:0] w_dif_ab;
    logic [WIDTH-1:0] w_sum_ai;
    logic             w_ovf_add;
    logic             w_ovf_sub;
    logic             w_ovf_addi;

    // Decode results
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ok;
    logic             w_is_mul;
    logic [2:0]       w_flg;
    logic             w_accept;

    // Multiplier completion interface (constant when the unit is absent)
    logic             w_fin;
    logic [WIDTH-1:0] w_mul_res;
    logic [2:0]       w_mul_flg;

    // Output stage
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;

`ifdef ALU_MULT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0]      c_FN_MFHI  = 6'h10;
    localparam logic [5:0]      c_FN_MFLO  = 6'h12;
    localparam logic [5:0]      c_FN_MULT  = 6'h18;
    localparam logic [5:0]      c_FN_MULTU = 6'h19;
    localparam logic [SH_W-1:0] c_CNT_LAST = SH_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [SH_W-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
`endif

    assign w_op     = instruction[31:26];
    assign w_funct  = instruction[5:0];
    // Shift amounts keep only the low log2(WIDTH) bits
    assign w_sa_imm = SH_W'(instruction[10:6]);
    assign w_sa_reg = reg_a[SH_W-1:0];
    assign w_sext   = WIDTH'($signed(instruction[15:0]));
    assign w_zext   = WIDTH'(instruction[15:0]);
    // rs/rt register-number fields are resolved upstream; operands arrive on reg_a/reg_b
    assign w_unused_fields = &{1'b0, instruction[25:16]};

    assign w_sum_ab   = reg_a + reg_b;
    assign w_dif_ab   = reg_a - reg_b;
    assign w_sum_ai   = reg_a + w_sext;
    assign w_ovf_add  = (reg_a[MSB] == reg_b[MSB])  && (w_sum_ab[MSB] != reg_a[MSB]);
    assign w_ovf_sub  = (reg_a[MSB] != reg_b[MSB])  && (w_dif_ab[MSB] != reg_a[MSB]);
    assign w_ovf_addi = (reg_a[MSB] == w_sext[MSB]) && (w_sum_ai[MSB] != reg_a[MSB]);

    // Instruction decode and single-cycle result selection
    always_comb begin
        w_res    = '0;
        w_ovf    = 1'b0;
        w_ok     = 1'b1;
        w_is_mul = 1'b0;
        if (w_op == c_OP_RTYPE) begin
            case (w_funct)
                c_FN_ADD:  begin w_res = w_sum_ab; w_ovf = w_ovf_add; end
                c_FN_ADDU: w_res = w_sum_ab;
                c_FN_SUB:  begin w_res = w_dif_ab; w_ovf = w_ovf_sub; end
                c_FN_SUBU: w_res = w_dif_ab;
                c_FN_AND:  w_res = reg_a & reg_b;
                c_FN_OR:   w_res = reg_a | reg_b;
                c_FN_XOR:  w_res = reg_a ^ reg_b;
                c_FN_NOR:  w_res = ~(reg_a | reg_b);
                c_FN_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
                c_FN_SLTU: w_res = {{(WIDTH-1){1'b0}}, (reg_a < reg_b)};
                c_FN_SLL:  w_res = reg_b << w_sa_imm;
                c_FN_SRL:  w_res = reg_b >> w_sa_imm;
                c_FN_SRA:  w_res = $signed(reg_b) >>> w_sa_imm;
                c_FN_SLLV: w_res = reg_b << w_sa_reg;
                c_FN_SRLV: w_res = reg_b >> w_sa_reg;
                c_FN_SRAV: w_res = $signed(reg_b) >>> w_sa_reg;
`ifdef ALU_MULT_EN
                c_FN_MFHI: w_res = r_hi;
                c_FN_MFLO: w_res = r_lo;
                c_FN_MULT, c_FN_MULTU: w_is_mul = 1'b1;
`endif
                default:   w_ok = 1'b0;
            endcase
        end else begin
            case (w_op)
                c_OP_ADDI:  begin w_res = w_sum_ai; w_ovf = w_ovf_addi; end
                c_OP_ADDIU: w_res = w_sum_ai;
                c_OP_SLTI:  w_res = {{(WIDTH-1){1'b0}}, ($signed(reg_a) < $signed(w_sext))};
                c_OP_SLTIU: w_res = {{(WIDTH-1){1'b0}}, (reg_a < w_sext)};
                c_OP_ANDI:  w_res = reg_a & w_zext;
                c_OP_ORI:   w_res = reg_a | w_zext;
                c_OP_XORI:  w_res = reg_a ^ w_zext;
                c_OP_BEQ, c_OP_BNE: w_res = w_dif_ab;
                c_OP_LW, c_OP_SW:   w_res = w_sum_ai;
                default:    w_ok = 1'b0;
            endcase
        end
        // Unsupported encodings fall through with result 0, which yields flags 001
        if (!w_ok) begin
            w_res = '0;
            w_ovf = 1'b0;
        end
    end

    assign w_flg    = {w_ovf, w_res[MSB], (w_res == '0)};
    assign in_ready = !busy && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ALU_MULT_EN
    assign busy       = (r_state == S_MUL);
    assign w_fin      = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);
    assign w_signed   = (w_funct == c_FN_MULT);
    assign w_a_mag    = (w_signed && reg_a[MSB]) ? ('0 - reg_a) : reg_a;
    assign w_b_mag    = (w_signed && reg_b[MSB]) ? ('0 - reg_b) : reg_b;
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    // The last step's sum is used directly so the product lands on the same edge
    assign w_prod     = r_neg ? ('0 - w_acc_step) : w_acc_step;
    assign w_mul_res  = w_prod[MSB:0];
    assign w_mul_flg  = {1'b0, w_prod[2*WIDTH-1], (w_prod == '0)};

    // Multiplier sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> MUL for WIDTH steps -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = (w_accept && w_is_mul) ? S_MUL : S_IDLE;
            S_MUL:          if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-add datapath on operand magnitudes plus HI/LO capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_neg    <= w_signed && (reg_a[MSB] ^ reg_b[MSB]);
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SH_W'(1);
            if (w_fin) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[MSB:0];
            end
        end
    end
`else
    assign busy      = 1'b0;
    assign w_fin     = 1'b0;
    assign w_mul_res = '0;
    assign w_mul_flg = '0;
`endif

    // Output register: load on accept or multiply completion, hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_fin) begin
            r_valid  <= 1'b1;
            r_result <= w_mul_res;
            r_flags  <= w_mul_flg;
        end else if (w_accept && !w_is_mul) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_flags  <= w_flg;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (WIDTH=32 and WIDTH=16).
//             Directed corner cases plus randomized traffic scored against
//             an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] instruction, reg_a, reg_b, result;
    logic [2:0]  flags;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [31:0] instruction16;
    logic [15:0] reg_a16, reg_b16, result16;
    logic [2:0]  flags16;

    int checks   = 0;
    int failures = 0;

    logic [34:0] exp_q[$];
    logic [5:0]  rfun [0:15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0]  iops [0:10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                 6'h04, 6'h05, 6'h23, 6'h2B};

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .reg_a(reg_a), .reg_b(reg_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .instruction(instruction16), .reg_a(reg_a16), .reg_b(reg_b16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .flags(flags16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for WIDTH=32: returns {overflow, negative, zero, result}
    function automatic logic [34:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, si, s, lim;
        logic [31:0] r, ui;
        logic        ov, ok;
        sa  = $signed(a);
        sb  = $signed(b);
        si  = $signed(ins[15:0]);
        ui  = {16'h0, ins[15:0]};
        lim = 64'sd2147483648;
        r = '0; ov = 1'b0; ok = 1'b1; s = 0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: begin s = sa + sb; r = s[31:0]; ov = (s >= lim) || (s < -lim); end
                6'h21: r = a + b;
                6'h22: begin s = sa - sb; r = s[31:0]; ov = (s >= lim) || (s < -lim); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = {31'b0, sa < sb};
                6'h2B: r = {31'b0, a < b};
                6'h00: r = b << ins[10:6];
                6'h02: r = b >> ins[10:6];
                6'h03: begin s = sb >>> ins[10:6]; r = s[31:0]; end
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: begin s = sb >>> a[4:0]; r = s[31:0]; end
                default: ok = 1'b0;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin s = sa + si; r = s[31:0]; ov = (s >= lim) || (s < -lim); end
                6'h09: begin s = sa + si; r = s[31:0]; end
                6'h0A: r = {31'b0, sa < si};
                6'h0B: begin s = si; r = {31'b0, a < s[31:0]}; end
                6'h0C: r = a & ui;
                6'h0D: r = a | ui;
                6'h0E: r = a ^ ui;
                6'h04, 6'h05: r = a - b;
                6'h23, 6'h2B: begin s = sa + si; r = s[31:0]; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) return {3'b001, 32'h0};
        return {ov, r[31], (r == 32'h0), r};
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom();
        k   = $urandom_range(0, 29);
        if (k < 16) begin
            ins[31:26] = 6'h00;
            ins[5:0]   = rfun[k];
        end else if (k < 27) begin
            ins[31:26] = iops[k-16];
        end
        // Keep multiplier-related functs out of the random stream
        if (ins[31:26] == 6'h00 && (ins[5:0] == 6'h10 || ins[5:0] == 6'h12 ||
                                    ins[5:0] == 6'h18 || ins[5:0] == 6'h19))
            ins[5:0] = 6'h3F;
        return ins;
    endfunction

    // Issue one instruction with out_ready high and check the registered result
    task automatic single(input string tag, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        out_ready   = 1'b1;
        instruction = ins;
        reg_a       = a;
        reg_b       = b;
        in_valid    = 1'b1;
        #1;
        for (int i = 0; i < 60 && !in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, flags, ef);
    endtask

`ifdef ALU_MULT_EN
    // Start a multiply, count cycles to out_valid and check LO and flags
    task automatic do_mult(input string tag, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] hi);
        longint      p;
        logic [63:0] pu;
        int          cyc;
        if (fn == 6'h18) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pu = p;
        end else begin
            pu = {32'h0, a} * {32'h0, b};
        end
        hi = pu[63:32];
        @(negedge clk);
        out_ready   = 1'b1;
        instruction = {26'h0, fn};
        reg_a       = a;
        reg_b       = b;
        in_valid    = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_busy"}, busy, 1);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_lo"}, result, pu[31:0]);
        chk({tag, "_flags"}, flags, {1'b0, pu[63], (pu == 64'h0)});
    endtask
`endif

    initial begin
        logic [34:0] e;
        logic [31:0] ins, hi, held_res;
        logic [2:0]  held_flg;
        logic        acc, cons, hold_prev, pend_acc, seen;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; reg_a = '0; reg_b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        instruction16 = '0; reg_a16 = '0; reg_b16 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Signed overflow on add
        single("add_ovf", 32'h0000_0020, 32'h7FFF_FFFF, 32'h0000_0006, 32'h8000_0005, 3'b110);

        // Back-to-back with stalled consumer
        @(negedge clk);
        out_ready = 1'b0;
        instruction = 32'h0000_0022; reg_a = 32'd4; reg_b = 32'd3;
        in_valid = 1'b1;
        #1;
        chk("b2b_in_ready0", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        instruction = 32'h0000_0021; reg_a = 32'd1; reg_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b_hold_valid", out_valid, 1);
            chk("b2b_hold_result", result, 32'h1);
            chk("b2b_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_first", result, 32'h1);
        chk("b2b_in_ready1", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second", result, 32'h3);
        @(negedge clk);
        #1;
        chk("b2b_no_dup", out_valid, 0);

        // Branch compare, unsigned immediate compare, unsupported encoding
        single("beq", 32'h1000_0000, 32'h5, 32'h5, 32'h0, 3'b001);
        single("sltiu", 32'h2C01_0010, 32'h100, 32'h0, 32'h0, 3'b001);
        single("unsup", 32'h0000_003F, 32'h1234, 32'h5678, 32'h0, 3'b001);
        single("sext_addiu", 32'h2400_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b010);
        single("zext_ori", 32'h3400_8000, 32'h0, 32'h0, 32'h0000_8000, 3'b000);
        single("sub_ovf", 32'h0000_0022, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b100);
        single("srav_mask", 32'h0000_0007, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 3'b010);

        // WIDTH=16 instance: arithmetic shift and 16-bit overflow
        @(negedge clk);
        instruction16 = 32'h0000_0103; reg_a16 = 16'h0; reg_b16 = 16'h8000;
        in_valid16 = 1'b1;
        #1;
        chk("w16_in_ready", in_ready16, 1);
        @(posedge clk);
        @(negedge clk);
        instruction16 = 32'h0000_0020; reg_a16 = 16'h7FFF; reg_b16 = 16'h0001;
        #1;
        chk("w16_sra_result", result16, 16'hF800);
        chk("w16_sra_flags", flags16, 3'b010);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        chk("w16_add_result", result16, 16'h8000);
        chk("w16_add_flags", flags16, 3'b110);

`ifdef ALU_MULT_EN
        do_mult("multu", 6'h19, 32'hFFFF_FFFF, 32'h2, hi);
        single("mfhi", 32'h0000_0010, 32'h0, 32'h0, 32'h1, 3'b000);
        for (int n = 0; n < 4; n++) begin
            do_mult("mult_rand", 6'h18, rand_opnd(), rand_opnd(), hi);
            single("mfhi_rand", 32'h0000_0010, 32'h0, 32'h0, hi,
                   {1'b0, hi[31], (hi == 32'h0)});
        end
        // Reset in the middle of a multiply
        @(negedge clk);
        instruction = 32'h0000_0019; reg_a = 32'hFFFF_FFFF; reg_b = 32'h2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        single("abort_mfhi", 32'h0000_0010, 32'h0, 32'h0, 32'h0, 3'b001);
        single("abort_mflo", 32'h0000_0012, 32'h0, 32'h0, 32'h0, 3'b001);
`else
        single("nomul_mfhi", 32'h0000_0010, 32'h1, 32'h2, 32'h0, 3'b001);
        single("nomul_multu", 32'h0000_0019, 32'hFFFF_FFFF, 32'h2, 32'h0, 3'b001);
        #1;
        chk("nomul_busy", busy, 0);
`endif

        // Randomized traffic with random backpressure
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        hold_prev = 1'b0; pend_acc = 1'b0;
        held_res = '0; held_flg = '0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (pend_acc) in_valid = 1'b0;
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                ins = rand_instr();
                instruction = ins;
                reg_a = rand_opnd();
                reg_b = rand_opnd();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (hold_prev) begin
                chk("rand_hold_valid", out_valid, 1);
                chk("rand_hold_result", {result, flags}, {held_res, held_flg});
            end
            if (cons) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_result", result, e[31:0]);
                    chk("rand_flags", flags, e[34:32]);
                end
            end
            if (acc) exp_q.push_back(model(instruction, reg_a, reg_b));
            hold_prev = out_valid && !out_ready;
            held_res  = result;
            held_flg  = flags;
            pend_acc  = acc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_result", result, e[31:0]);
                    chk("drain_flags", flags, e[34:32]);
                end
            end
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
